level_sequencer: RTL and testbench
==================================

// Module: level_sequencer
// PURPOSE
//  Parametrised game-flow sequencer: menu -> N timed stages -> win screens, with lives, pause
//  and game-over. Owns its own stage timer, advanced by a frame tick, instead of decoding an
//  external time bus. Sits between input debounce/tick logic and the obstacle/render blocks.
//  Drives the one-hot stage select, the object-counter reset pulse and the screen flags.
// PARAMETERS
//  N_STAGES   20   number of play stages (>=2)
//  STAGE_LEN  125  ticks per stage (>=2)
//  LIVES      3    lives per game (1..15)
//  TIMER_W    16   stage-timer width; must satisfy STAGE_LEN <= 2**TIMER_W-1
// PORTS
//  clk             in   1            system clock
//  reset           in   1            synchronous, active-low reset
//  tick            in   1            1-cycle frame tick; timer advances only on tick
//  user_sel        in   1            debounced button level; rising edge = "select"
//  pause_req       in   1            level: hold play while high
//  player_died     in   1            1-cycle death pulse from collision logic
//  stage_onehot    out  N_STAGES     bit k = 1 iff in PLAY/PAUSE and stage_idx==k
//  stage_idx       out  $clog2(N_STAGES)  current stage index
//  stage_timer     out  TIMER_W      ticks elapsed in current stage
//  lives_left      out  4            remaining lives
//  reset_obj_count out  1            1-cycle pulse on every stage (re)entry
//  menu_screen     out  1            state==MENU
//  win_screen      out  1            state==WIN_DELAY or WIN
//  over_screen     out  1            state==GAME_OVER
//  paused          out  1            state==PAUSE
// BEHAVIOUR
//  Reset (reset==0 at clk edge): state=MENU, stage_idx=0, stage_timer=0, lives_left=LIVES,
//   every output pulse 0, sel edge detector primed with the current user_sel level, so a
//   button held through reset produces no edge. Reset overrides every other input.
//  sel_edge = user_sel & ~user_sel_q (registered); only sel_edge is acted upon.
//  States: MENU, PLAY, PAUSE, WIN_DELAY, WIN, GAME_OVER.
//  MENU: on sel_edge -> PLAY, stage_idx=0, timer=0, lives=LIVES, pulse reset_obj_count.
//  PLAY, priority high->low:
//   1 player_died: lives-1; if the result is >0, stay in PLAY, timer=0, keep stage_idx
//     (checkpoint), pulse reset_obj_count; if the result is 0 -> GAME_OVER.
//   2 pause_req -> PAUSE (the timer does not advance this cycle even if tick=1).
//   3 tick with timer==STAGE_LEN-1: if stage_idx==N_STAGES-1 -> WIN_DELAY; else stage_idx+1,
//     timer=0, pulse reset_obj_count.
//   4 tick otherwise: timer+1.
//  PAUSE: timer and stage frozen, player_died ignored; pause_req==0 -> PLAY next cycle.
//  WIN_DELAY: sel_edge -> WIN.  WIN: sel_edge -> MENU.  GAME_OVER: sel_edge -> MENU.
//  A death and the final-stage tick in the same cycle: the death wins (no win).
//  reset_obj_count is registered and high exactly 1 cycle, on the cycle after the event.
//  stage_onehot is all-zero outside PLAY/PAUSE; it is never multi-hot.
//  An undefined state encoding recovers to MENU on the next cycle.
// STRUCTURE
//  level_pkg: game_state_t enum, LIVES_W=4 constant, shared with render and score blocks.
//  Sub-module edge_rise (1-bit rising-edge detector, synchronous active-low reset); one
//  instance on user_sel. One always_ff for state/counters, one always_comb for the next state.
// TESTING (N_STAGES=4, STAGE_LEN=3, LIVES=2 unless stated)
//  1 reset low with user_sel held high, then released -> MENU, no transition until the button
//    is released and pressed again.
//  2 sel_edge, 12 ticks -> stage_idx 0,1,2,3 with one reset_obj_count per entry (4 total),
//    then WIN_DELAY; sel_edge -> WIN, sel_edge -> MENU.
//  3 death in stage 2 at timer=1 -> lives=1, stage_idx=2, timer=0, 1 pulse; a second death
//    -> GAME_OVER, stage_onehot=0.
//  4 pause_req high for 10 ticks in stage 1 -> timer and stage unchanged; release -> resumes.
//  5 death and final tick in the same cycle -> GAME_OVER when lives_left was 1, else a restart
//    of stage 3.
//  6 reset low in mid-PLAY for 1 cycle -> MENU, lives=2, all pulses 0; held user_sel causes
//    no skip.

Source files
------------

// File: rtl/level_pkg.sv
// Shared game-flow types for the level sequencer, render and score blocks.
package level_pkg;

    localparam int LIVES_W = 4;

    typedef enum logic [2:0] {
        ST_MENU      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_WIN_DELAY = 3'd3,
        ST_WIN       = 3'd4,
        ST_GAME_OVER = 3'd5
    } game_state_t;

    // A stage is "live" (selected on the one-hot bus) while playing or paused.
    function automatic logic shows_stage(input game_state_t s);
        return (s == ST_PLAY) || (s == ST_PAUSE);
    endfunction

endpackage

// File: rtl/level_sequencer_edge_rise.sv
// One-bit rising-edge detector; the history register tracks the input even in reset,
// so a level held through reset never reads as an edge afterwards.
module edge_rise (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        d_q <= d_i;
    end

    assign rise_o = reset & d_i & ~d_q;

endmodule

// File: rtl/level_sequencer.sv
// Game-flow sequencer: menu -> N timed stages -> win screens, with lives, pause and game-over.
// Owns the stage timer, advanced only by the frame tick.
module level_sequencer
    import level_pkg::*;
#(
    parameter int N_STAGES  = 20,
    parameter int STAGE_LEN = 125,
    parameter int LIVES     = 3,
    parameter int TIMER_W   = 16,
    localparam int IDX_W    = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                user_sel,
    input  logic                pause_req,
    input  logic                player_died,
    output logic [N_STAGES-1:0] stage_onehot,
    output logic [IDX_W-1:0]    stage_idx,
    output logic [TIMER_W-1:0]  stage_timer,
    output logic [LIVES_W-1:0]  lives_left,
    output logic                reset_obj_count,
    output logic                menu_screen,
    output logic                win_screen,
    output logic                over_screen,
    output logic                paused
);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(STAGE_LEN - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_STAGES - 1);
    localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);

    game_state_t          state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [LIVES_W-1:0]   lives_q, lives_d;
    logic                 obj_pulse_q, obj_pulse_d;
    logic                 sel_edge;

    edge_rise u_sel_edge (
        .clk    (clk),
        .reset  (reset),
        .d_i    (user_sel),
        .rise_o (sel_edge)
    );

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latches).
        state_d     = state_q;
        idx_d       = idx_q;
        timer_d     = timer_q;
        lives_d     = lives_q;
        obj_pulse_d = 1'b0;

        case (state_q)
            ST_MENU: begin
                if (sel_edge) begin
                    state_d     = ST_PLAY;
                    idx_d       = '0;
                    timer_d     = '0;
                    lives_d     = LIVES_INIT;
                    obj_pulse_d = 1'b1;
                end
            end
            ST_PLAY: begin
                if (player_died) begin
                    lives_d = lives_q - LIVES_W'(1);
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = ST_GAME_OVER;
                        lives_d = '0;
                    end else begin
                        // Checkpoint: replay the current stage from its start.
                        timer_d     = '0;
                        obj_pulse_d = 1'b1;
                    end
                end else if (pause_req) begin
                    state_d = ST_PAUSE;
                end else if (tick) begin
                    if (timer_q == TIMER_LAST) begin
                        if (idx_q == IDX_LAST) begin
                            state_d = ST_WIN_DELAY;
                        end else begin
                            idx_d       = idx_q + IDX_W'(1);
                            timer_d     = '0;
                            obj_pulse_d = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TIMER_W'(1);
                    end
                end
            end
            ST_PAUSE: begin
                if (!pause_req) state_d = ST_PLAY;
            end
            ST_WIN_DELAY: begin
                if (sel_edge) state_d = ST_WIN;
            end
            ST_WIN, ST_GAME_OVER: begin
                if (sel_edge) state_d = ST_MENU;
            end
            default: begin
                state_d = ST_MENU;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_MENU;
            idx_q       <= '0;
            timer_q     <= '0;
            lives_q     <= LIVES_INIT;
            obj_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            lives_q     <= lives_d;
            obj_pulse_q <= obj_pulse_d;
        end
    end

    always_comb begin
        stage_onehot = '0;
        for (int k = 0; k < N_STAGES; k++) begin
            stage_onehot[k] = shows_stage(state_q) && (idx_q == IDX_W'(k));
        end
    end

    assign stage_idx       = idx_q;
    assign stage_timer     = timer_q;
    assign lives_left      = lives_q;
    assign reset_obj_count = obj_pulse_q;
    assign menu_screen     = (state_q == ST_MENU);
    assign win_screen      = (state_q == ST_WIN_DELAY) || (state_q == ST_WIN);
    assign over_screen     = (state_q == ST_GAME_OVER);
    assign paused          = (state_q == ST_PAUSE);

endmodule

// File: tb/tb_level_sequencer.sv
// Scoreboarded bench for level_sequencer: directed game scenarios followed by random play,
// every cycle compared against a progress-based reference model.
module tb_level_sequencer;

    localparam int N_STAGES  = 4;
    localparam int STAGE_LEN = 3;
    localparam int LIVES     = 2;
    localparam int TIMER_W   = 16;
    localparam int IDX_W     = 2;
    localparam int OBS_W     = N_STAGES + IDX_W + TIMER_W + 4 + 5;

    localparam int MD_MENU = 0, MD_PLAY = 1, MD_PAUSE = 2, MD_WDLY = 3, MD_WIN = 4, MD_OVER = 5;

    logic                clk = 1'b0;
    logic                reset, tick, user_sel, pause_req, player_died;
    logic [N_STAGES-1:0] stage_onehot;
    logic [IDX_W-1:0]    stage_idx;
    logic [TIMER_W-1:0]  stage_timer;
    logic [3:0]          lives_left;
    logic                reset_obj_count, menu_screen, win_screen, over_screen, paused;

    level_sequencer #(
        .N_STAGES (N_STAGES), .STAGE_LEN(STAGE_LEN), .LIVES(LIVES), .TIMER_W(TIMER_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .user_sel       (user_sel),
        .pause_req      (pause_req),
        .player_died    (player_died),
        .stage_onehot   (stage_onehot),
        .stage_idx      (stage_idx),
        .stage_timer    (stage_timer),
        .lives_left     (lives_left),
        .reset_obj_count(reset_obj_count),
        .menu_screen    (menu_screen),
        .win_screen     (win_screen),
        .over_screen    (over_screen),
        .paused         (paused)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cycle_no = 0;

    logic [OBS_W-1:0] exp_q[$];

    // Model: game progress is total ticks elapsed; stage and timer are derived from it.
    int m_mode     = MD_MENU;
    int m_elapsed  = 0;
    int m_lives    = LIVES;
    bit m_pulse    = 1'b0;
    bit m_sel_prev = 1'b0;

    logic rst_lvl, sel_lvl, pz_lvl;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_update(input bit rst, input bit sel, input bit tk, input bit pz, input bit die);
        bit edge_seen;
        edge_seen  = sel && !m_sel_prev;
        m_sel_prev = sel;
        m_pulse    = 1'b0;
        if (!rst) begin
            m_mode    = MD_MENU;
            m_elapsed = 0;
            m_lives   = LIVES;
            return;
        end
        case (m_mode)
            MD_MENU: if (edge_seen) begin
                m_mode = MD_PLAY; m_elapsed = 0; m_lives = LIVES; m_pulse = 1'b1;
            end
            MD_PLAY: begin
                if (die) begin
                    m_lives--;
                    if (m_lives > 0) begin
                        m_elapsed = (m_elapsed / STAGE_LEN) * STAGE_LEN;
                        m_pulse   = 1'b1;
                    end else begin
                        m_mode = MD_OVER;
                    end
                end else if (pz) begin
                    m_mode = MD_PAUSE;
                end else if (tk) begin
                    if (m_elapsed + 1 == N_STAGES * STAGE_LEN) begin
                        m_mode = MD_WDLY;
                    end else begin
                        m_elapsed++;
                        m_pulse = (m_elapsed % STAGE_LEN) == 0;
                    end
                end
            end
            MD_PAUSE: if (!pz) m_mode = MD_PLAY;
            MD_WDLY:  if (edge_seen) m_mode = MD_WIN;
            MD_WIN:   if (edge_seen) m_mode = MD_MENU;
            MD_OVER:  if (edge_seen) m_mode = MD_MENU;
            default:  m_mode = MD_MENU;
        endcase
    endtask

    function automatic logic [OBS_W-1:0] model_obs();
        logic [N_STAGES-1:0] oh;
        int stage;
        stage = m_elapsed / STAGE_LEN;
        oh = (m_mode == MD_PLAY || m_mode == MD_PAUSE) ? N_STAGES'(1 << stage) : '0;
        return {oh, IDX_W'(stage), TIMER_W'(m_elapsed % STAGE_LEN), 4'(m_lives), m_pulse,
                m_mode == MD_MENU, (m_mode == MD_WDLY) || (m_mode == MD_WIN),
                m_mode == MD_OVER, m_mode == MD_PAUSE};
    endfunction

    // One clock cycle of stimulus; the expected post-edge outputs are queued for the monitor.
    task automatic cyc(input logic tk = 1'b0, input logic die = 1'b0);
        @(negedge clk);
        reset       = rst_lvl;
        user_sel    = sel_lvl;
        pause_req   = pz_lvl;
        tick        = tk;
        player_died = die;
        model_update(rst_lvl, sel_lvl, tk, pz_lvl, die);
        exp_q.push_back(model_obs());
    endtask

    task automatic press();
        sel_lvl = 1'b1; cyc();
        sel_lvl = 1'b0; cyc();
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    initial begin : monitor
        logic [OBS_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("cycle %0d outputs", cycle_no),
                      64'({stage_onehot, stage_idx, stage_timer, lives_left, reset_obj_count,
                           menu_screen, win_screen, over_screen, paused}), 64'(e));
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int waited;
        rst_lvl = 1'b0; sel_lvl = 1'b1; pz_lvl = 1'b0;
        reset = 1'b0; user_sel = 1'b1; pause_req = 1'b0; tick = 1'b0; player_died = 1'b0;

        // Button held through reset must not start a game.
        repeat (3) cyc();
        rst_lvl = 1'b1;
        repeat (4) cyc(1'b1);
        settle();
        check("held sel stays in menu", 64'(menu_screen), 64'(1));
        sel_lvl = 1'b0; cyc();

        // Full run through all stages to the win screens.
        press();
        for (int i = 0; i < N_STAGES * STAGE_LEN; i++) begin
            cyc(1'b1);
            cyc(1'b0);
        end
        settle();
        check("win_delay reached", 64'(win_screen), 64'(1));
        press();
        press();
        settle();
        check("back to menu after win", 64'(menu_screen), 64'(1));

        // Death at stage 2 timer 1, then a second death ends the game.
        press();
        repeat (2 * STAGE_LEN + 1) cyc(1'b1);
        cyc(1'b0, 1'b1);
        repeat (2) cyc();
        cyc(1'b0, 1'b1);
        settle();
        check("game over flag", 64'(over_screen), 64'(1));
        check("onehot clear in game over", 64'(stage_onehot), 64'(0));
        press();

        // Pause in stage 1 freezes timer and ignores ticks and deaths.
        press();
        repeat (STAGE_LEN + 1) cyc(1'b1);
        pz_lvl = 1'b1; cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, (i == 4));
        settle();
        check("paused flag", 64'(paused), 64'(1));
        check("timer frozen in pause", 64'(stage_timer), 64'(1));
        pz_lvl = 1'b0; cyc();
        repeat (5) cyc(1'b1);

        // Death coinciding with the final tick: restart stage 3, then game over.
        rst_lvl = 1'b0; cyc();
        rst_lvl = 1'b1; cyc();
        press();
        repeat (N_STAGES * STAGE_LEN - 1) cyc(1'b1);
        cyc(1'b1, 1'b1);
        repeat (STAGE_LEN - 1) cyc(1'b1);
        cyc(1'b1, 1'b1);
        settle();
        check("death beats final tick", 64'(over_screen), 64'(1));
        press();

        // One-cycle reset mid-play with the button held.
        press();
        repeat (4) cyc(1'b1);
        sel_lvl = 1'b1;
        rst_lvl = 1'b0; cyc();
        rst_lvl = 1'b1;
        repeat (3) cyc(1'b1);
        settle();
        check("mid-play reset to menu", 64'(menu_screen), 64'(1));
        sel_lvl = 1'b0; cyc();

        // Randomised play.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(5, 0) == 0)   sel_lvl = ~sel_lvl;
            if ($urandom_range(19, 0) == 0)  pz_lvl  = ~pz_lvl;
            rst_lvl = ($urandom_range(299, 0) != 0);
            cyc(1'($urandom_range(1, 0)), ($urandom_range(24, 0) == 0));
        end
        rst_lvl = 1'b1; pz_lvl = 1'b0; sel_lvl = 1'b0;
        repeat (2) cyc();

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            settle();
            waited++;
        end
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
